// File: rtl/jt49_bus_master.sv
// jt49_bus_master: FIFO-fed PSG bus master driving BDIR/BC1/DA; JT49_READBACK_EN adds register reads
module jt49_bus_master #(
  parameter int FIFO_AW   = 2,
  parameter int LATCH_CYC = 2,
  parameter int WRITE_CYC = 2,
  parameter int GAP_CYC   = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cen,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic [3:0] wr_addr,
  input  logic [7:0] wr_data,
`ifdef JT49_READBACK_EN
  input  logic       wr_rd,
  input  logic [7:0] din,
  output logic       rd_valid,
  output logic [7:0] rd_data,
`endif
  output logic       bdir,
  output logic       bc1,
  output logic [7:0] dout,
  output logic       busy
);
`ifdef JT49_READBACK_EN
  localparam int EW = 13;
  typedef enum logic [2:0] {IDLE, LATCH, LGAP, WRITE, WGAP, READ} state_t;
`else
  localparam int EW = 12;
  typedef enum logic [2:0] {IDLE, LATCH, LGAP, WRITE, WGAP} state_t;
`endif
  typedef logic [FIFO_AW:0] count_t;
  logic [EW-1:0] mem_q [2**FIFO_AW];
  logic [EW-1:0] head, wr_entry;
  logic [FIFO_AW-1:0] wp_q, rp_q;
  count_t count_q;
  state_t state_q, sstate;
  logic [7:0] cnt_q, data_q, dout_q, sdata, sdout;
  logic [3:0] addr_q, cache_q;
  logic cache_valid_q, bdir_q, bc1_q, push, pop, empty, last, sbdir, sbc1;
  assign head     = mem_q[rp_q];
  assign empty    = count_q == '0;
  assign wr_ready = !count_q[FIFO_AW];
  assign push     = wr_valid && wr_ready;
  assign pop      = cen && state_q == IDLE && !empty;
  assign busy     = !empty || state_q != IDLE;
  assign last     = cnt_q == 8'd0;
  assign sdata    = state_q == IDLE ? head[7:0] : data_q;
  assign bdir     = bdir_q;
  assign bc1      = bc1_q;
  assign dout     = dout_q;
`ifdef JT49_READBACK_EN
  logic rd_q, rd_valid_q, srd;
  logic [7:0] rd_data_q;
  assign wr_entry = {wr_rd, wr_addr, wr_data};
  assign srd      = state_q == IDLE ? head[12] : rd_q;
  assign sstate   = srd ? READ : WRITE;
  assign sbdir    = !srd;
  assign sbc1     = srd;
  assign sdout    = srd ? 8'h00 : sdata;
  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;
`else
  assign wr_entry = {wr_addr, wr_data};
  assign sstate   = WRITE;
  assign sbdir    = 1'b1;
  assign sbc1     = 1'b0;
  assign sdout    = sdata;
`endif
  always_ff @(posedge clk) begin
    if (push) mem_q[wp_q] <= wr_entry;
    if (rst) begin
      wp_q          <= '0;
      rp_q          <= '0;
      count_q       <= '0;
      state_q       <= IDLE;
      cnt_q         <= 8'd0;
      data_q        <= 8'h00;
      addr_q        <= 4'h0;
      cache_q       <= 4'h0;
      cache_valid_q <= 1'b0;
      bdir_q        <= 1'b0;
      bc1_q         <= 1'b0;
      dout_q        <= 8'h00;
`ifdef JT49_READBACK_EN
      rd_q          <= 1'b0;
      rd_valid_q    <= 1'b0;
      rd_data_q     <= 8'h00;
`endif
    end else begin
      wp_q    <= wp_q + FIFO_AW'(push);
      rp_q    <= rp_q + FIFO_AW'(pop);
      count_q <= count_q + count_t'(push) - count_t'(pop);
`ifdef JT49_READBACK_EN
      rd_valid_q <= 1'b0;
`endif
      if (cen) begin
        cnt_q <= cnt_q - 8'd1;
        case (state_q)
          IDLE: if (!empty) begin
            addr_q <= head[11:8];
            data_q <= head[7:0];
`ifdef JT49_READBACK_EN
            rd_q   <= head[12];
`endif
            // a repeat of the last latched register skips straight to the strobe
            if (cache_valid_q && head[11:8] == cache_q) begin
              state_q <= sstate;
              cnt_q   <= 8'(WRITE_CYC - 1);
              bdir_q  <= sbdir;
              bc1_q   <= sbc1;
              dout_q  <= sdout;
            end else begin
              state_q <= LATCH;
              cnt_q   <= 8'(LATCH_CYC - 1);
              bdir_q  <= 1'b1;
              bc1_q   <= 1'b1;
              dout_q  <= {4'h0, head[11:8]};
            end
          end
          LATCH: if (last) begin
            cache_q       <= addr_q;
            cache_valid_q <= 1'b1;
            state_q       <= LGAP;
            cnt_q         <= 8'(GAP_CYC - 1);
            bdir_q        <= 1'b0;
            bc1_q         <= 1'b0;
          end
          LGAP: if (last) begin
            state_q <= sstate;
            cnt_q   <= 8'(WRITE_CYC - 1);
            bdir_q  <= sbdir;
            bc1_q   <= sbc1;
            dout_q  <= sdout;
          end
          WRITE: if (last) begin
            state_q <= WGAP;
            cnt_q   <= 8'(GAP_CYC - 1);
            bdir_q  <= 1'b0;
            bc1_q   <= 1'b0;
          end
`ifdef JT49_READBACK_EN
          READ: if (last) begin
            rd_data_q  <= din;
            rd_valid_q <= 1'b1;
            state_q    <= WGAP;
            cnt_q      <= 8'(GAP_CYC - 1);
            bdir_q     <= 1'b0;
            bc1_q      <= 1'b0;
          end
`endif
          WGAP: if (last) state_q <= IDLE;
          default: state_q <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_jt49_bus_master.sv
// tb_jt49_bus_master: directed scoreboard bench for jt49_bus_master (readback test under JT49_READBACK_EN)
module tb_jt49_bus_master;
  typedef struct packed {logic bdir; logic bc1; logic [7:0] dout;} bus_t;
  logic clk = 1'b0, rst = 1'b1, cen = 1'b1, wr_valid = 1'b0;
  logic [3:0] wr_addr = 4'h0;
  logic [7:0] wr_data = 8'h00;
  logic wr_ready, bdir, bc1, busy;
  logic [7:0] dout;
  int checks = 0, errors = 0, tk;
  bus_t exp_q[$];
`ifdef JT49_READBACK_EN
  logic wr_rd = 1'b0, rd_valid;
  logic [7:0] din = 8'h00, rd_data;
`endif
  jt49_bus_master dut (
    .clk(clk), .rst(rst), .cen(cen), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_data(wr_data),
`ifdef JT49_READBACK_EN
    .wr_rd(wr_rd), .din(din), .rd_valid(rd_valid), .rd_data(rd_data),
`endif
    .bdir(bdir), .bc1(bc1), .dout(dout), .busy(busy)
  );
  always #5 clk = ~clk;
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end
  task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic chk_bus(input string tag);
    bus_t e;
    checks++;
    assert (exp_q.size() != 0) else begin
      errors++;
      $error("FAIL %s: got empty scoreboard expected an entry", tag);
    end
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk(tag, {bdir, bc1, dout}, e);
    end
  endtask
  task automatic push_req(input logic [3:0] a, input logic [7:0] d);
    @(negedge clk);
    wr_valid = 1'b1;
    wr_addr  = a;
    wr_data  = d;
    @(negedge clk);
    wr_valid = 1'b0;
  endtask
  // Expected per-clock bus samples for one write at cen=1, ending with the IDLE clock
  task automatic exp_write(input logic [3:0] a, input logic [7:0] d, input bit latched);
    if (latched) begin
      repeat (2) exp_q.push_back({2'b11, 4'h0, a});
      exp_q.push_back({2'b00, 4'h0, a});
    end
    repeat (2) exp_q.push_back({2'b10, d});
    repeat (2) exp_q.push_back({2'b00, d});
  endtask
  task automatic run_bus(input string tag, input int n);
    repeat (n) begin
      @(negedge clk);
      chk_bus(tag);
    end
  endtask
  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("reset_bus", {bdir, bc1, dout}, 10'h000);
    chk("reset_ready", 10'(wr_ready), 10'd1);
    chk("reset_busy", 10'(busy), 10'd0);
    push_req(4'd7, 8'h38);
    chk("queued_busy", 10'(busy), 10'd1);
    exp_write(4'd7, 8'h38, 1'b1);
    run_bus("single_write", 7);
    chk("single_idle_busy", 10'(busy), 10'd0);
    push_req(4'd7, 8'h3F);
    exp_write(4'd7, 8'h3F, 1'b0);
    run_bus("cached_write", 4);
    chk("cached_idle_busy", 10'(busy), 10'd0);
    cen = 1'b0;
    @(negedge clk);
    wr_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wr_addr = 4'(i);
      wr_data = 8'h10 + 8'(i);
      @(negedge clk);
    end
    chk("full_ready", 10'(wr_ready), 10'd0);
    wr_addr = 4'd9;
    wr_data = 8'hEE;
    @(negedge clk);
    wr_valid = 1'b0;
    chk("full_ready_hold", 10'(wr_ready), 10'd0);
    cen = 1'b1;
    for (int i = 0; i < 4; i++) exp_write(4'(i), 8'h10 + 8'(i), 1'b1);
    @(negedge clk);
    chk_bus("bp_write");
    chk("bp_ready_after_pop", 10'(wr_ready), 10'd1);
    run_bus("bp_write", 27);
    chk("bp_drained", 10'(busy), 10'd0);
    cen = 1'b0;
    push_req(4'd5, 8'h55);
    push_req(4'd6, 8'h77);
    cen = 1'b1;
    exp_write(4'd5, 8'h55, 1'b1);
    run_bus("pre_reset", 4);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    chk("midrst_bus", {bdir, bc1, dout}, 10'h000);
    chk("midrst_ready", 10'(wr_ready), 10'd1);
    chk("midrst_busy", 10'(busy), 10'd0);
    push_req(4'd5, 8'h66);
    exp_write(4'd5, 8'h66, 1'b1);
    run_bus("post_reset_latch", 7);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    cen = 1'b0;
    push_req(4'd13, 8'h0E);
    tk = 0;
    for (int i = 0; i < 32; i++) begin
      cen = (i % 4 == 0);
      @(negedge clk);
      if (cen) tk++;
      exp_q.push_back(tk == 0 ? 10'h000 :
                      tk <= 2 ? {2'b11, 8'h0D} :
                      tk == 3 ? {2'b00, 8'h0D} :
                      tk <= 5 ? {2'b10, 8'h0E} : {2'b00, 8'h0E});
      chk_bus("slow_cen");
      if (i % 4 == 1) chk("slow_busy", 10'(busy), 10'(tk < 7));
    end
    cen = 1'b1;
`ifdef JT49_READBACK_EN
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    wr_rd = 1'b1;
    din = 8'hA5;
    push_req(4'd14, 8'hFF);
    wr_rd = 1'b0;
    repeat (2) exp_q.push_back({2'b11, 8'h0E});
    exp_q.push_back({2'b00, 8'h0E});
    repeat (2) exp_q.push_back({2'b01, 8'h00});
    repeat (2) exp_q.push_back({2'b00, 8'h00});
    for (int i = 1; i <= 7; i++) begin
      @(negedge clk);
      chk_bus("read_bus");
      chk("rd_valid", 10'(rd_valid), 10'(i == 6));
      if (i == 6) chk("rd_data", 10'(rd_data), 10'h0A5);
    end
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/jt49_bus_master.md
Name: jt49_bus_master

Overview:
- Register-write front end that drives the PSG CPU bus (BDIR/BC1/DA) from a queue of (address, data) requests.
- It is the initiator end of the bus that the PSG register file and the envelope/tone/noise blocks consume. For example, a write to register 13 is what restarts the envelope.
- Sits between a host/sequencer (valid/ready stream) and the PSG core. Bus timing is paced by the same cen as the core.

Parameters:
- FIFO_AW, 2, log2 of request FIFO depth (default depth 4).
- LATCH_CYC, 2, cen ticks the address-latch phase lasts (>=1).
- WRITE_CYC, 2, cen ticks the write (or read) strobe phase lasts (>=1).
- GAP_CYC, 1, cen ticks of inactive bus after each strobe phase (>=1).

Ports:
- clk  in  1  clock, same clock as the PSG core.
- rst  in  1  synchronous, active-high reset.
- cen  in  1  clock enable; all bus timing advances only on cycles with cen=1.
- wr_valid  in  1  request valid.
- wr_ready  out  1  request accepted when wr_valid&&wr_ready; equals !fifo_full.
- wr_addr  in  4  PSG register number.
- wr_data  in  8  data to write.
- bdir  out  1  PSG BDIR.
- bc1  out  1  PSG BC1.
- dout  out  8  PSG DA bus value.
- busy  out  1  1 while FIFO non-empty or state!=IDLE.

Behaviour:
- Clocking and reset: one clock. Reset is synchronous and active-high on rst. All state and outputs update on posedge clk.
- Reset values: bdir=0, bc1=0, dout=8'h00, FIFO empty, wr_ready=1, busy=0, addr cache invalid, state IDLE.
- Reset mid-operation: on the next edge everything returns to reset values. The in-flight request and queued entries are discarded.
- FIFO push: on any clk with wr_valid&&wr_ready, independent of cen. Entries are popped in order.
- FIFO simultaneous push and pop: count is unchanged.
- FIFO full: wr_ready=0 and wr_valid is ignored.
- States: IDLE, LATCH, LGAP, WRITE, WGAP.
- IDLE:
  - On a cen tick with the FIFO non-empty, pop the head.
  - If cache_valid and head addr==cached addr, go to WRITE; otherwise go to LATCH.
- Phase counter: on entering a phase, the counter loads N-1. Each later cen tick decrements it. The phase exits on the cen tick where the counter is 0, so each phase spans exactly N cen ticks. Phase lengths are LATCH=LATCH_CYC, LGAP/WGAP=GAP_CYC, WRITE=WRITE_CYC.
- LATCH: bdir=1, bc1=1, dout={4'h0,addr}. On exit: cached addr=addr, cache_valid=1, go to LGAP.
- LGAP: bdir=0, bc1=0, dout holds its value. On exit go to WRITE.
- WRITE: bdir=1, bc1=0, dout=data. On exit go to WGAP.
- WGAP: bdir=0, bc1=0, dout holds. On exit go to IDLE.
- IDLE→next request: the pop can happen on the cen tick immediately after WGAP exit. There are no back-to-back strobes without a gap.
- Output timing: outputs are registered and change only on clk edges where cen=1 (or on reset).
- Example with cen=1 constantly and defaults: a latched write gives bdir/bc1 = 11,11,00,10,10,00 starting the clock after the pop. A cached-address write gives 10,10,00.
- cen=0 for any length: the state is frozen, outputs are held, and the FIFO still accepts pushes.

Optional Feature:
- Macro: JT49_READBACK_EN.
- Additional ports:
  - wr_rd in 1: the request is a read and wr_data is ignored.
  - din in 8: PSG DA input.
  - rd_valid out 1: reset 0.
  - rd_data out 8: reset 8'h00.
- FIFO entries carry the rd bit.
- Read request flow: LATCH/LGAP as for a write (the address cache applies), then READ replaces WRITE.
  - READ: bdir=0, bc1=1, dout=8'h00, lasting WRITE_CYC ticks.
  - On the exit tick of READ, capture din into rd_data and pulse rd_valid high for exactly one clk. Then go to WGAP.
- Without the macro: no wr_rd/din/rd_valid/rd_data ports, no READ state, and FIFO entries are 12 bits.

Test Plan:
- Single write: cen=1, push addr=7 data=8'h38 → bdir/bc1 = 11,11,00,10,10,00; dout=8'h07 during LATCH/LGAP and 8'h38 during WRITE/WGAP; busy returns to 0.
- Cached address: after the test above, push addr=7 data=8'h3F → bdir/bc1 = 10,10,00 with no latch phase; dout=8'h3F.
- Backpressure: cen=0, push 4 entries (addr 0..3), attempt a 5th → wr_ready=0 after the 4th and the 5th is not stored; then cen=1 → four latched writes in order 0,1,2,3, with wr_ready=1 after the first pop.
- Slow cen: cen high every 4th clk, push addr=13 data=8'h0E → each phase lasts 4x clocks (LATCH 8 clks), outputs change only on cen clocks, total 24 clks.
- Reset mid-write: assert rst during WRITE → next clk bdir=bc1=0, dout=8'h00, wr_ready=1, busy=0; a new write to the same addr performs a LATCH phase (cache cleared).
- JT49_READBACK_EN: read addr=14 with din=8'hA5 → bdir/bc1 = 11,11,00,01,01,00; rd_valid is a one-clk pulse with rd_data=8'hA5 on the exit edge of READ.
